// File: rtl/mem_access_sequencer.sv
// Main-memory access sequencer: arbitrates fetch vs data requests and drives
// the MAR/MDR/RAM strobes through ADDR -> RD_WAIT -> RD_OUT or ADDR -> WR.
module mem_access_sequencer #(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic data_req,
  input  logic data_we,
  output logic fetch_grant,
  output logic data_grant,
  output logic addr_phase,
  output logic wdata_phase,
  output logic MAR_in,
  output logic MDR_in,
  output logic MDR_out,
  output logic read_from_MM,
  output logic write_to_MM,
  output logic fetch_done,
  output logic data_done,
  output logic busy
);

  // 0 wait states would leave RD_WAIT/WR with no exit count, so clamp to 1..15
  localparam logic [3:0] W_LOAD = (WAIT_STATES < 1)  ? 4'd1  :
                                  (WAIT_STATES > 15) ? 4'd15 : 4'(WAIT_STATES);

  typedef enum logic [2:0] {IDLE, ADDR, RD_WAIT, RD_OUT, WR} state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       we_r, we_n;
  logic       last_data, last_n;   // last_grant: 1 = DATA, 0 = FETCH
  logic       own_data, own_n;     // current owner: 1 = data, 0 = fetch

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we_n    = we_r;
    last_n  = last_data;
    own_n   = own_data;
    case (state)
      IDLE: begin
        // round robin only matters when both are asking
        if (data_req && (!fetch_req || !last_data)) begin
          own_n   = 1'b1;
          we_n    = data_we;
          last_n  = 1'b1;
          state_n = ADDR;
        end else if (fetch_req) begin
          own_n   = 1'b0;
          we_n    = 1'b0;
          last_n  = 1'b0;
          state_n = ADDR;
        end
      end
      ADDR: begin
        cnt_n   = W_LOAD;
        state_n = we_r ? WR : RD_WAIT;
      end
      RD_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RD_OUT;
      end
      RD_OUT: state_n = IDLE;
      WR: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe and never see a request input combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      we_r         <= 1'b0;
      last_data    <= 1'b0;
      own_data     <= 1'b0;
      fetch_grant  <= 1'b0;
      data_grant   <= 1'b0;
      addr_phase   <= 1'b0;
      wdata_phase  <= 1'b0;
      MAR_in       <= 1'b0;
      MDR_in       <= 1'b0;
      MDR_out      <= 1'b0;
      read_from_MM <= 1'b0;
      write_to_MM  <= 1'b0;
      fetch_done   <= 1'b0;
      data_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      we_r         <= we_n;
      last_data    <= last_n;
      own_data     <= own_n;
      busy         <= (state_n != IDLE);
      fetch_grant  <= (state_n != IDLE) && !own_n;
      data_grant   <= (state_n != IDLE) &&  own_n;
      addr_phase   <= (state_n == ADDR);
      MAR_in       <= (state_n == ADDR);
      read_from_MM <= (state_n == RD_WAIT);
      MDR_out      <= (state_n == RD_OUT);
      wdata_phase  <= (state_n == WR);
      MDR_in       <= (state_n == WR);
      write_to_MM  <= (state_n == WR);
      fetch_done   <= (state_n == RD_OUT) && !own_n;
      // a write commits on its last strobe cycle, so done rides with it
      data_done    <= ((state_n == RD_OUT) && own_n) ||
                      ((state_n == WR) && (cnt_n == 4'd1));
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench: three sequencers (WAIT_STATES 1..3); stimulus pushes expected
// address/done/abort events, a negedge monitor pops and compares them.
module tb_mem_access_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic fetch_req, data_req, data_we;
  int   sel;
  int   cyc = 0;

  logic [3:1] fg, dg, ap, wp, mi, mdi, mdo, rd, wr, fd, dd, bz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    mem_access_sequencer #(.WAIT_STATES(g)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .fetch_req    (fetch_req && (sel == g)),
      .data_req     (data_req && (sel == g)),
      .data_we      (data_we),
      .fetch_grant  (fg[g]),
      .data_grant   (dg[g]),
      .addr_phase   (ap[g]),
      .wdata_phase  (wp[g]),
      .MAR_in       (mi[g]),
      .MDR_in       (mdi[g]),
      .MDR_out      (mdo[g]),
      .read_from_MM (rd[g]),
      .write_to_MM  (wr[g]),
      .fetch_done   (fd[g]),
      .data_done    (dd[g]),
      .busy         (bz[g])
    );
  end

  typedef struct {int cyc; bit dat; bit wr; int n;} exp_t;
  exp_t aq[$];
  exp_t dq[$];
  int   zq[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d (W=%0d)", name, got, exp, cyc, sel);
  endtask

  task automatic push_a(input int c, input bit dat);
    exp_t e;
    e.cyc = c; e.dat = dat; e.wr = 1'b0; e.n = 0;
    aq.push_back(e);
  endtask

  task automatic push_d(input int c, input bit dat, input bit w, input int n);
    exp_t e;
    e.cyc = c; e.dat = dat; e.wr = w; e.n = n;
    dq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor
  initial begin
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    bit   idle_chk = 1'b0;
    exp_t e;
    logic [11:0] v;
    forever begin
      @(negedge clk);
      v = {fg[sel], dg[sel], ap[sel], wp[sel], mi[sel], mdi[sel], mdo[sel],
           rd[sel], wr[sel], fd[sel], dd[sel], bz[sel]};
      check("exclusion", {rd[sel] & wr[sel], mdi[sel] & mdo[sel],
                          mi[sel] & (rd[sel] | wr[sel]), fg[sel] & dg[sel],
                          ~bz[sel] & (fg[sel] | dg[sel])}, 0);
      check("phase_align", {mi[sel] ^ ap[sel], wr[sel] ^ mdi[sel], wr[sel] ^ wp[sel]}, 0);
      if (idle_chk) begin
        check("idle_after_done", {bz[sel], fg[sel], dg[sel]}, 0);
        idle_chk = 1'b0;
      end
      if (zq.size() > 0 && zq[0] == cyc) begin
        void'(zq.pop_front());
        check("reset_zero", v, 0);
      end
      if (mi[sel]) begin
        rd_cnt = 0;
        wr_cnt = 0;
        if (aq.size() == 0) check("unexpected_addr", 1, 0);
        else begin
          e = aq.pop_front();
          check("addr_cycle", cyc, e.cyc);
          check("addr_grant", {dg[sel], fg[sel]}, e.dat ? 2 : 1);
        end
      end
      if (rd[sel]) rd_cnt++;
      if (wr[sel]) wr_cnt++;
      if (fd[sel] || dd[sel]) begin
        idle_chk = 1'b1;
        if (dq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = dq.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("done_owner", {dd[sel], fd[sel]}, e.dat ? 2 : 1);
          check("done_grant", {dg[sel], fg[sel]}, e.dat ? 2 : 1);
          check("done_mdr_out", mdo[sel], e.wr ? 0 : 1);
          check("done_strobes", e.wr ? wr_cnt : rd_cnt, e.n);
        end
      end
    end
  end

  // stimulus
  initial begin
    int c0;
    sel = 1; reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    tick(2);
    zq.push_back(cyc);
    reset = 1'b0;
    tick(1);

    // W=1 fetch read
    sel = 1; c0 = cyc; fetch_req = 1'b1;
    push_a(c0 + 1, 1'b0); push_d(c0 + 3, 1'b0, 1'b0, 1);
    tick(4); fetch_req = 1'b0;
    tick(2);

    // W=3 data write
    sel = 3; c0 = cyc; data_req = 1'b1; data_we = 1'b1;
    push_a(c0 + 1, 1'b1); push_d(c0 + 4, 1'b1, 1'b1, 3);
    tick(5); data_req = 1'b0; data_we = 1'b0;
    tick(2);

    // W=1 both held from reset: DATA, FETCH, DATA, FETCH every 4 cycles
    sel = 1; reset = 1'b1;
    tick(1);
    reset = 1'b0; c0 = cyc; fetch_req = 1'b1; data_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_a(c0 + 1 + 4 * k, (k % 2) == 0);
      push_d(c0 + 3 + 4 * k, (k % 2) == 0, 1'b0, 1);
    end
    tick(16); fetch_req = 1'b0; data_req = 1'b0;
    tick(2);

    // W=2 data read aborted by reset in first RD_WAIT cycle, then both request
    sel = 2; c0 = cyc; data_req = 1'b1;
    push_a(c0 + 1, 1'b1);
    tick(2); reset = 1'b1; zq.push_back(c0 + 3);
    tick(1); reset = 1'b0; fetch_req = 1'b1;
    push_a(c0 + 4, 1'b1); push_d(c0 + 7, 1'b1, 1'b0, 2);
    tick(5); fetch_req = 1'b0; data_req = 1'b0;
    tick(2);

    // W=2 read with data_we toggled and data_req dropped mid-access
    sel = 2; c0 = cyc; data_req = 1'b1; data_we = 1'b0;
    push_a(c0 + 1, 1'b1); push_d(c0 + 4, 1'b1, 1'b0, 2);
    tick(2); data_we = 1'b1; data_req = 1'b0;
    tick(6); data_we = 1'b0;
    tick(2);

    check("addr_queue_left", aq.size(), 0);
    check("done_queue_left", dq.size(), 0);
    check("zero_queue_left", zq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
